// File: rtl/mem_load_unit.sv
// mem_load_unit -- MEM-stage load engine.
//
// Accepts a load (type code, byte address, destination register), issues a
// single aligned word read on the dmem req/gnt/rvalid bus, then extracts the
// byte/half/word, sign- or zero-extends it, and returns a registered result
// with its rd to writeback.
//
// Load-type codes: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; 101-111 behave as lw.
//
// Optional feature macro: LOAD_MISALIGN_TRAP_EN
//   defined   : misaligned lw/lh/lhu are not issued; they raise a misalign_exc pulse.
//   undefined : misalign_exc is tied 0; misaligned loads are issued and
//               formatted from the low address bits.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   ld_req/ld_type/ld_addr/ld_rd  load request (sampled only when busy=0)
//   flush                    kill in-flight load
//   busy                     load in progress
//   dmem_req/dmem_addr       word read request, held until dmem_gnt
//   dmem_gnt/dmem_rvalid/dmem_rdata  memory handshake and data
//   wb_valid/wb_rd/wb_data   1-cycle result pulse; rd/data hold between pulses
//   bus_err                  1-cycle pulse on rvalid timeout
//   misalign_exc             1-cycle pulse on trapped misaligned load
module mem_load_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_rd,
  input  logic        flush,
  output logic        busy,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misalign_exc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

`ifdef LOAD_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, EXC} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN} state_t;
`endif

  state_t          state, nstate;
  logic [CW-1:0]   cnt;
  logic [2:0]      lat_type;
  logic [1:0]      lat_off;
  logic [4:0]      lat_rd;

  logic accept, cnt_clr, wb_load, tmo_hit, timeout;
`ifdef LOAD_MISALIGN_TRAP_EN
  logic misal, exc_fire;
`endif

  function automatic logic [31:0] fmt(input logic [2:0] t, input logic [1:0] off,
                                      input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = d[16*off[1] +: 16];
    case (t)
      3'b001:  fmt = {{24{b[7]}}, b};
      3'b011:  fmt = {24'b0, b};
      3'b010:  fmt = {{16{h[15]}}, h};
      3'b100:  fmt = {16'b0, h};
      default: fmt = d;
    endcase
  endfunction

  // The wait window is counted in WAIT/DRAIN cycles since the grant (or flush);
  // rvalid in the cycle where the counter sits at TIMEOUT_CYCLES-1 still counts.
  assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1)) && !dmem_rvalid;

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misal = ((ld_type == 3'b000) && (ld_addr[1:0] != 2'b00)) ||
                 (((ld_type == 3'b010) || (ld_type == 3'b100)) && ld_addr[0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate   = state;
    accept   = 1'b0;
    cnt_clr  = 1'b0;
    wb_load  = 1'b0;
    timeout  = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
    exc_fire = 1'b0;
`endif
    case (state)
      IDLE: if (ld_req) begin
        accept = 1'b1;
`ifdef LOAD_MISALIGN_TRAP_EN
        nstate = misal ? EXC : REQ;
`else
        nstate = REQ;
`endif
      end
      REQ: begin
        if (flush) nstate = IDLE;
        else if (dmem_gnt) begin
          nstate  = WAIT;
          cnt_clr = 1'b1;
        end
      end
      WAIT: begin
        // flush beats rvalid; if data is already here there is nothing to drain
        if (flush) begin
          nstate  = dmem_rvalid ? IDLE : DRAIN;
          cnt_clr = 1'b1;
        end else if (dmem_rvalid) begin
          wb_load = 1'b1;
          nstate  = IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          nstate  = IDLE;
        end
      end
      DRAIN: begin
        if (dmem_rvalid) nstate = IDLE;
        else if (tmo_hit) begin
          timeout = 1'b1;
          nstate  = IDLE;
        end
      end
`ifdef LOAD_MISALIGN_TRAP_EN
      EXC: begin
        exc_fire = 1'b1;
        nstate   = IDLE;
      end
`endif
      default: nstate = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign dmem_req = (state == REQ);
  assign bus_err  = timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if ((state == WAIT) || (state == DRAIN)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_type  <= 3'b0;
      lat_off   <= 2'b0;
      lat_rd    <= 5'b0;
      dmem_addr <= 32'b0;
    end else if (accept) begin
      lat_type  <= ld_type;
      lat_off   <= ld_addr[1:0];
      lat_rd    <= ld_rd;
      dmem_addr <= {ld_addr[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= 5'b0;
      wb_data  <= 32'b0;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_rd   <= lat_rd;
        wb_data <= fmt(lat_type, lat_off, dmem_rdata);
      end
`ifdef LOAD_MISALIGN_TRAP_EN
      else if (exc_fire) wb_rd <= lat_rd;
`endif
    end
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_exc <= 1'b0;
    else     misalign_exc <= exc_fire;
  end
`else
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;

`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req = 1'b0;
  logic [2:0]  ld_type = 3'b0;
  logic [31:0] ld_addr = 32'b0;
  logic [4:0]  ld_rd = 5'b0;
  logic        flush = 1'b0;
  logic        busy, dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err, misalign_exc;

  int ntests = 0;
  int nfail  = 0;

  mem_load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .ld_type(ld_type), .ld_addr(ld_addr),
    .ld_rd(ld_rd), .flush(flush), .busy(busy), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte lanes, pick by shifting, extend arithmetically.
  function automatic logic [31:0] model(input logic [2:0] t, input logic [31:0] a,
                                        input logic [31:0] d);
    int unsigned off, v;
    off = a % 4;
    case (t)
      3'd1, 3'd3: begin
        v = (d >> (8 * off)) % 256;
        if (t == 3'd1 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd2, 3'd4: begin
        v = (d >> (16 * (off / 2))) % 65536;
        if (t == 3'd2 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // Full load transaction; gd = extra cycles before gnt, rv = WAIT cycles before rvalid.
  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] d, input int gd,
                         input int rv);
    logic [31:0] exp;
    bit mis;
    exp = model(t, a, d);
    mis = TRAP && (((t == 3'd0) && (a % 4 != 0)) || (((t == 3'd2) || (t == 3'd4)) && a[0]));
    chk({tag, "_idle"}, busy, 0);
    ld_req = 1'b1; ld_type = t; ld_addr = a; ld_rd = rd;
    tick;
    ld_req = 1'b0; ld_addr = $urandom; ld_type = 3'($urandom); ld_rd = 5'($urandom);
    if (mis) begin
      chk({tag, "_exc_noreq"}, dmem_req, 0);
      chk({tag, "_exc_busy"}, busy, 1);
      tick;
      chk({tag, "_exc_pulse"}, misalign_exc, 1);
      chk({tag, "_exc_nowb"}, wb_valid, 0);
      chk({tag, "_exc_rd"}, wb_rd, rd);
      tick;
      chk({tag, "_exc_end"}, misalign_exc, 0);
      chk({tag, "_exc_idle"}, busy, 0);
      return;
    end
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    for (int i = 0; i < gd; i++) begin
      ld_req = 1'b1;  // must be ignored while busy
      tick;
      chk({tag, "_req_hold"}, dmem_req, 1);
      chk({tag, "_addr_hold"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, "_busy_hold"}, busy, 1);
    end
    ld_req = 1'b0;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    chk({tag, "_req_drop"}, dmem_req, 0);
    for (int i = 0; i < rv; i++) begin
      tick;
      chk({tag, "_wait_nowb"}, wb_valid, 0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = d;
    tick;
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, wb_rd, rd);
    chk({tag, "_done"}, busy, 0);
    tick;
    chk({tag, "_wbv_pulse"}, wb_valid, 0);
    chk({tag, "_data_hold"}, wb_data, exp);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_buserr", bus_err, 0);
    chk("rst_misal", misalign_exc, 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // directed formatting cases
    do_load("lb103", 3'd1, 32'h103, 5'd7, 32'h80AA_BBCC, 0, 0);
    chk("lb103_val", wb_data, TRAP ? wb_data : 32'hFFFF_FF80);
    do_load("lhu102", 3'd4, 32'h102, 5'd8, 32'h8001_1234, 0, 1);
    do_load("lh100", 3'd2, 32'h100, 5'd9, 32'h8001_1234, 0, 0);
    chk("lh100_val", wb_data, 32'h0000_1234);
    // gnt held off 5 cycles; second ld_req ignored
    do_load("gnt5", 3'd0, 32'h100, 5'd10, 32'hDEAD_BEEF, 5, 2);
    do_load("lw101", 3'd0, 32'h101, 5'd11, 32'h1234_5678, 0, 0);

    // flush in WAIT, rvalid two cycles later -> drained
    ld_req = 1'b1; ld_type = 3'd1; ld_addr = 32'h200; ld_rd = 5'd12;
    tick; ld_req = 1'b0;
    dmem_gnt = 1'b1; tick; dmem_gnt = 1'b0;
    flush = 1'b1; tick; flush = 1'b0;
    chk("drain_busy", busy, 1);
    tick;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
    chk("drain_busy2", busy, 1);
    tick; dmem_rvalid = 1'b0;
    chk("drain_nowb", wb_valid, 0);
    chk("drain_idle", busy, 0);
    do_load("after_drain", 3'd3, 32'h203, 5'd13, 32'hF0E0_D0C0, 0, 0);

    // flush and rvalid in the same WAIT cycle
    ld_req = 1'b1; ld_type = 3'd0; ld_addr = 32'h300; ld_rd = 5'd14;
    tick; ld_req = 1'b0;
    dmem_gnt = 1'b1; tick; dmem_gnt = 1'b0;
    flush = 1'b1; dmem_rvalid = 1'b1; tick; flush = 1'b0; dmem_rvalid = 1'b0;
    chk("flrv_nowb", wb_valid, 0);
    chk("flrv_idle", busy, 0);

    // flush in REQ beats gnt; then rvalid/flush in IDLE are ignored
    ld_req = 1'b1; ld_type = 3'd0; ld_addr = 32'h400; ld_rd = 5'd15;
    tick; ld_req = 1'b0;
    flush = 1'b1; dmem_gnt = 1'b1; tick; flush = 1'b0; dmem_gnt = 1'b0;
    chk("flreq_idle", busy, 0);
    chk("flreq_noreq", dmem_req, 0);
    dmem_rvalid = 1'b1; flush = 1'b1; tick; dmem_rvalid = 1'b0; flush = 1'b0;
    chk("idle_rv_nowb", wb_valid, 0);
    chk("idle_rv_busy", busy, 0);

    // timeout: gnt at cycle 1, no rvalid -> bus_err at cycle 5
    ld_req = 1'b1; ld_type = 3'd0; ld_addr = 32'h500; ld_rd = 5'd16;
    tick; ld_req = 1'b0;
    dmem_gnt = 1'b1; tick; dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo_early", bus_err, 0);
      tick;
    end
    chk("tmo_pulse", bus_err, 1);
    chk("tmo_busy", busy, 1);
    tick;
    chk("tmo_end", bus_err, 0);
    chk("tmo_idle", busy, 0);
    chk("tmo_nowb", wb_valid, 0);

    // async reset while in REQ
    ld_req = 1'b1; ld_type = 3'd0; ld_addr = 32'h600; ld_rd = 5'd17;
    tick; ld_req = 1'b0;
    chk("arst_pre", dmem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", dmem_addr, 0);
    tick;
    rst = 1'b0;
    tick;

    // randomized loads against the reference model
    for (int n = 0; n < 40; n++) begin
      do_load("rnd", 3'($urandom_range(0, 7)), $urandom, 5'($urandom),
              $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
